prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Run controller for the fetch stage. It holds fetch in Init, selects the program start slot via ProgState, releases fetch and watches for Halt. It counts execution cycles with a watchdog, then reports completion and advances to the next program slot. It sits between the testbench or top-level start logic and the instruction-fetch block, and owns that block's Init and ProgState inputs.

## Interface
- NUM_PROGS, 3: number of program slots. Legal range 1..4. Slot i drives ProgState = i.
- INIT_CYCLES, 2: cycles Init is held high before each run. Minimum 1.
- TIMEOUT, 1023: maximum RUN cycles before forced completion. Minimum 2.
- CNT_W, 16: cycle counter width. Must satisfy 2^CNT_W > TIMEOUT.
- CLK  in  1  clock; all state changes on posedge only.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  run request; sampled only in IDLE.
- Abort  in  1  cancel current run; sampled in INIT and RUN.
- Halt  in  1  done flag from fetch stage.
- Init  out  1  to fetch stage; high holds PC at the slot start address.
- ProgState  out  2  start-slot select to fetch stage.
- Busy  out  1  high in INIT, RUN and DONE.
- Done  out  1  one-cycle completion pulse.
- DoneProg  out  2  slot index of the last completed run.
- CycleCount  out  CNT_W  RUN-cycle count of the last completed run.
- Timeout  out  1  last completed run ended by the watchdog.

## Operation
- Internal registers: state in {IDLE, INIT, RUN, DONE}, slot (2b), init counter, run counter (CNT_W), armed bit.
- IDLE: Init=1, ProgState=slot, Busy=0. Start=1 at an edge -> INIT; init counter loads INIT_CYCLES-1.
- INIT: Init=1, ProgState=slot.
  - Init counter decrements; at 0 -> RUN.
  - Run counter clears to 0; armed clears.
- RUN: Init=0, ProgState=slot.
  - Run counter increments every RUN cycle.
  - Halt is ignored on the first RUN cycle (armed=0), because fetch holds a stale Halt through Init. Armed sets after that cycle.
  - Armed and Halt=1 -> DONE with Timeout=0.
  - Run counter reaches TIMEOUT with no qualifying Halt -> DONE with Timeout=1.
  - Qualifying Halt and watchdog expiry in the same cycle: Halt wins, Timeout=0.
- DONE: lasts one cycle.
  - Done=1, Init=1.
  - DoneProg<=slot; CycleCount<=run counter value including the terminating cycle.
  - slot <= (slot==NUM_PROGS-1) ? 0 : slot+1.
  - Next state is IDLE.
- Abort=1 in INIT or RUN -> IDLE next edge. No Done, slot unchanged, CycleCount/DoneProg/Timeout unchanged.
- Start outside IDLE is ignored, not queued.
- Start held high: IDLE lasts one cycle, then the next slot launches.

## Timing
- All outputs are registered or decoded from registered state only. No combinational input-to-output path.
- Reset (Reset_n=0 at an edge), from any state including mid-run:
  - state=IDLE, slot=0.
  - Init=1, ProgState=0, Busy=0, Done=0.
  - DoneProg=0, CycleCount=0, Timeout=0.
- Start sampled at edge k:
  - INIT occupies cycles k+1..k+INIT_CYCLES.
  - First RUN cycle (Init=0) is k+INIT_CYCLES+1.
- Halt sampled high on the n-th RUN cycle (n≥2):
  - DONE occupies the next cycle; Done=1 there; CycleCount=n visible from that cycle.
  - Init returns high in the same cycle as Done.
- Watchdog: DONE follows the TIMEOUT-th RUN cycle, with CycleCount=TIMEOUT.
- ProgState changes only on entry to IDLE from DONE. It is stable throughout INIT and RUN.

## Test plan
- Reset: hold Reset_n=0 for 2 edges mid-RUN -> Init=1, ProgState=0, Busy=0, Done=0, CycleCount=0, Timeout=0 on the next cycle.
- Normal run (INIT_CYCLES=2, TIMEOUT=100): Start pulse, Halt pulsed on RUN cycle 20 -> Init low for exactly 20 cycles, one Done pulse, CycleCount=20, DoneProg=0, Timeout=0, ProgState=1.
- Stale Halt: Halt held 1 through INIT and RUN cycle 1, low after, pulsed on RUN cycle 5 -> no Done before cycle 5; CycleCount=5.
- Watchdog: Start, Halt never asserted -> Done after 100 RUN cycles, CycleCount=100, Timeout=1. Halt on cycle 100 instead -> Timeout=0.
- Wrap and back-to-back: Start held 1, Halt after 10 cycles each run -> ProgState sequence 0,1,2,0, DoneProg 0,1,2, one IDLE cycle between runs.
- Abort: Abort on RUN cycle 7 -> IDLE next cycle, no Done, slot unchanged; following Start reruns the same slot.

Source files
------------

// File: rtl/prog_sequencer.sv
// Run controller for the fetch stage: holds fetch in Init, selects the program slot,
// releases fetch, watches Halt with a watchdog, then reports completion and advances slot.
//
// state | meaning
// IDLE  | waiting for Start; fetch held in Init at the current slot
// INIT  | Init held for INIT_CYCLES cycles before the run
// RUN   | fetch released; run counter and watchdog active
// DONE  | one-cycle completion pulse; slot advances on exit
module prog_sequencer #(
  parameter int NUM_PROGS   = 3,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Halt,
  output logic             Init,
  output logic [1:0]       ProgState,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       DoneProg,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Timeout
);

  localparam int               IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0]    INIT_LOAD = IW'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       LAST_SLOT = 2'(NUM_PROGS - 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [IW-1:0]    init_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             armed;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state      <= IDLE;
      slot       <= 2'd0;
      init_cnt   <= '0;
      run_cnt    <= '0;
      armed      <= 1'b0;
      DoneProg   <= 2'd0;
      CycleCount <= '0;
      Timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= INIT;
            init_cnt <= INIT_LOAD;
          end
        end
        INIT: begin
          run_cnt <= '0;
          armed   <= 1'b0;
          if (Abort)
            state <= IDLE;
          else if (init_cnt == '0)
            state <= RUN;
          else
            init_cnt <= init_cnt - 1'b1;
        end
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          // fetch still shows the previous run's Halt on the first RUN cycle
          armed   <= 1'b1;
          if (Abort) begin
            state <= IDLE;
          end else if ((armed && Halt) || (run_cnt == RUN_LAST)) begin
            state      <= DONE;
            DoneProg   <= slot;
            CycleCount <= run_cnt + 1'b1;
            Timeout    <= !(armed && Halt);
          end
        end
        DONE: begin
          state <= IDLE;
          slot  <= (slot == LAST_SLOT) ? 2'd0 : slot + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Init      = (state != RUN);
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign ProgState = slot;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: reset, normal run, stale Halt, watchdog,
// back-to-back slot wrap and abort, with hand-computed expectations.
module tb_prog_sequencer;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        Halt = 1'b0;
  logic        Init;
  logic [1:0]  ProgState;
  logic        Busy;
  logic        Done;
  logic [1:0]  DoneProg;
  logic [15:0] CycleCount;
  logic        Timeout;

  int vecs = 0;
  int errs = 0;

  prog_sequencer #(
    .NUM_PROGS(3), .INIT_CYCLES(2), .TIMEOUT(100), .CNT_W(16)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Abort(Abort), .Halt(Halt),
    .Init(Init), .ProgState(ProgState), .Busy(Busy), .Done(Done),
    .DoneProg(DoneProg), .CycleCount(CycleCount), .Timeout(Timeout)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start pulse; returns in what should be the first RUN cycle
  task automatic launch();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    vecs++; if (Init !== 1'b1) begin errs++; $display("FAIL rst_init got %b want 1", Init); end
    vecs++; if (ProgState !== 2'd0) begin errs++; $display("FAIL rst_progstate got %0d want 0", ProgState); end
    vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", Busy); end
    vecs++; if (Done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", Done); end
    vecs++; if (DoneProg !== 2'd0) begin errs++; $display("FAIL rst_doneprog got %0d want 0", DoneProg); end
    vecs++; if (CycleCount !== 16'd0) begin errs++; $display("FAIL rst_cyclecount got %0d want 0", CycleCount); end
    vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL rst_timeout got %b want 0", Timeout); end
    Reset_n = 1'b1;
    tick();
    vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL rst_idle_hold got busy %b want 0", Busy); end
  endtask

  task automatic test_normal();
    int low = 0;
    int dones = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    vecs++; if ({Init, Busy} !== 2'b11) begin errs++; $display("FAIL norm_init1 got init/busy %b want 11", {Init, Busy}); end
    tick();
    vecs++; if (Init !== 1'b1) begin errs++; $display("FAIL norm_init2 got %b want 1", Init); end
    tick();
    for (int n = 1; n <= 20; n++) begin
      if (Init === 1'b0) low++;
      if (Done === 1'b1) dones++;
      Halt = (n == 20);
      tick();
    end
    Halt = 1'b0;
    vecs++; if (low != 20) begin errs++; $display("FAIL norm_init_low got %0d cycles want 20", low); end
    vecs++; if (dones != 0) begin errs++; $display("FAIL norm_early_done got %0d want 0", dones); end
    vecs++; if (Done !== 1'b1) begin errs++; $display("FAIL norm_done got %b want 1", Done); end
    vecs++; if (Init !== 1'b1) begin errs++; $display("FAIL norm_init_done got %b want 1", Init); end
    vecs++; if (CycleCount !== 16'd20) begin errs++; $display("FAIL norm_cyclecount got %0d want 20", CycleCount); end
    vecs++; if (DoneProg !== 2'd0) begin errs++; $display("FAIL norm_doneprog got %0d want 0", DoneProg); end
    vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL norm_timeout got %b want 0", Timeout); end
    vecs++; if (ProgState !== 2'd0) begin errs++; $display("FAIL norm_ps_in_done got %0d want 0", ProgState); end
    tick();
    vecs++; if ({Done, Busy} !== 2'b00) begin errs++; $display("FAIL norm_idle got done/busy %b want 00", {Done, Busy}); end
    vecs++; if (ProgState !== 2'd1) begin errs++; $display("FAIL norm_ps_next got %0d want 1", ProgState); end
  endtask

  task automatic test_reset_midrun();
    launch();
    for (int n = 1; n <= 5; n++) tick();
    vecs++; if (Init !== 1'b0) begin errs++; $display("FAIL midrst_running got init %b want 0", Init); end
    Reset_n = 1'b0;
    tick();
    tick();
    vecs++; if (Init !== 1'b1) begin errs++; $display("FAIL midrst_init got %b want 1", Init); end
    vecs++; if (ProgState !== 2'd0) begin errs++; $display("FAIL midrst_ps got %0d want 0", ProgState); end
    vecs++; if ({Busy, Done} !== 2'b00) begin errs++; $display("FAIL midrst_busy_done got %b want 00", {Busy, Done}); end
    vecs++; if (CycleCount !== 16'd0) begin errs++; $display("FAIL midrst_cyclecount got %0d want 0", CycleCount); end
    vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL midrst_timeout got %b want 0", Timeout); end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_stale_halt();
    int early = 0;
    Halt = 1'b1;
    launch();
    vecs++; if (Init !== 1'b0) begin errs++; $display("FAIL stale_run1 got init %b want 0", Init); end
    tick();
    Halt = 1'b0;
    for (int n = 2; n <= 5; n++) begin
      if (Done !== 1'b0 || Init !== 1'b0) early++;
      Halt = (n == 5);
      tick();
    end
    Halt = 1'b0;
    vecs++; if (early != 0) begin errs++; $display("FAIL stale_early_done got %0d bad cycles want 0", early); end
    vecs++; if (Done !== 1'b1) begin errs++; $display("FAIL stale_done got %b want 1", Done); end
    vecs++; if (CycleCount !== 16'd5) begin errs++; $display("FAIL stale_cyclecount got %0d want 5", CycleCount); end
    vecs++; if (DoneProg !== 2'd0) begin errs++; $display("FAIL stale_doneprog got %0d want 0", DoneProg); end
    tick();
  endtask

  task automatic test_watchdog();
    int early = 0;
    launch();
    for (int n = 1; n <= 100; n++) begin
      if (Done !== 1'b0 || Init !== 1'b0) early++;
      tick();
    end
    vecs++; if (early != 0) begin errs++; $display("FAIL wd_early got %0d bad cycles want 0", early); end
    vecs++; if (Done !== 1'b1) begin errs++; $display("FAIL wd_done got %b want 1", Done); end
    vecs++; if (CycleCount !== 16'd100) begin errs++; $display("FAIL wd_cyclecount got %0d want 100", CycleCount); end
    vecs++; if (Timeout !== 1'b1) begin errs++; $display("FAIL wd_timeout got %b want 1", Timeout); end
    vecs++; if (DoneProg !== 2'd1) begin errs++; $display("FAIL wd_doneprog got %0d want 1", DoneProg); end
    tick();
    launch();
    for (int n = 1; n <= 100; n++) begin
      Halt = (n == 100);
      tick();
    end
    Halt = 1'b0;
    vecs++; if (Done !== 1'b1) begin errs++; $display("FAIL wdh_done got %b want 1", Done); end
    vecs++; if (CycleCount !== 16'd100) begin errs++; $display("FAIL wdh_cyclecount got %0d want 100", CycleCount); end
    vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL wdh_timeout got %b want 0", Timeout); end
    vecs++; if (DoneProg !== 2'd2) begin errs++; $display("FAIL wdh_doneprog got %0d want 2", DoneProg); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ps [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    int runs = 0;
    int rc = 0;
    int gap = 0;
    Start = 1'b1;
    for (int c = 0; c < 400 && runs < 4; c++) begin
      tick();
      if (Busy === 1'b0) gap++;
      if (Init === 1'b0) begin
        rc++;
        if (rc == 1) begin
          vecs++; if (ProgState !== exp_ps[runs]) begin errs++; $display("FAIL b2b_ps run %0d got %0d want %0d", runs, ProgState, exp_ps[runs]); end
          if (runs > 0) begin
            vecs++; if (gap != 1) begin errs++; $display("FAIL b2b_gap run %0d got %0d idle cycles want 1", runs, gap); end
          end
          if (runs == 3) Start = 1'b0;
        end
        Halt = (rc == 10);
      end else begin
        Halt = 1'b0;
      end
      if (Done === 1'b1) begin
        vecs++; if (DoneProg !== exp_ps[runs]) begin errs++; $display("FAIL b2b_doneprog run %0d got %0d want %0d", runs, DoneProg, exp_ps[runs]); end
        vecs++; if (CycleCount !== 16'd10) begin errs++; $display("FAIL b2b_cyclecount run %0d got %0d want 10", runs, CycleCount); end
        runs++;
        rc = 0;
        gap = 0;
      end
    end
    Start = 1'b0;
    Halt = 1'b0;
    vecs++; if (runs != 4) begin errs++; $display("FAIL b2b_runs got %0d completed want 4", runs); end
    tick();
    tick();
    vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL b2b_no_queue got busy %b want 0", Busy); end
  endtask

  task automatic test_abort();
    int bad = 0;
    launch();
    for (int n = 1; n <= 7; n++) begin
      Abort = (n == 7);
      tick();
    end
    Abort = 1'b0;
    vecs++; if ({Busy, Done, Init} !== 3'b001) begin errs++; $display("FAIL abort_idle got busy/done/init %b want 001", {Busy, Done, Init}); end
    vecs++; if (ProgState !== 2'd1) begin errs++; $display("FAIL abort_ps got %0d want 1", ProgState); end
    vecs++; if (CycleCount !== 16'd10) begin errs++; $display("FAIL abort_cyclecount got %0d want 10", CycleCount); end
    vecs++; if (DoneProg !== 2'd0) begin errs++; $display("FAIL abort_doneprog got %0d want 0", DoneProg); end
    vecs++; if (Timeout !== 1'b0) begin errs++; $display("FAIL abort_timeout got %b want 0", Timeout); end
    for (int n = 0; n < 3; n++) begin
      tick();
      if (Done !== 1'b0 || Busy !== 1'b0) bad++;
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL abort_quiet got %0d bad cycles want 0", bad); end
    launch();
    vecs++; if ({Init, ProgState} !== 3'b001) begin errs++; $display("FAIL abort_rerun got init/ps %b want 001", {Init, ProgState}); end
    for (int n = 1; n <= 3; n++) begin
      Halt = (n == 3);
      tick();
    end
    Halt = 1'b0;
    vecs++; if (Done !== 1'b1) begin errs++; $display("FAIL abort_rerun_done got %b want 1", Done); end
    vecs++; if (DoneProg !== 2'd1) begin errs++; $display("FAIL abort_rerun_doneprog got %0d want 1", DoneProg); end
    vecs++; if (CycleCount !== 16'd3) begin errs++; $display("FAIL abort_rerun_cyclecount got %0d want 3", CycleCount); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish within bound");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    test_reset();
    test_normal();
    test_reset_midrun();
    test_stale_halt();
    test_watchdog();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
